// File: rtl/csr_ram_port_arbiter_if.sv
// Request/response and RAM command bundle shared by the two requesters and the
// arbiter. The slave modport is the arbiter side and the master modport is the environment side.
interface csr_ram_port_arbiter_if #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int WORD_ADDR_BIT_WIDTH = 6
);
    localparam int BE_W = WORD_BIT_WIDTH / 8;

    logic [1:0]                          i_req;
    logic [1:0]                          i_req_is_wr;
    logic [1:0][WORD_ADDR_BIT_WIDTH-1:0] i_req_word_addr;
    logic [1:0][WORD_BIT_WIDTH-1:0]      i_req_wr_data;
    logic [1:0][BE_W-1:0]                i_req_wr_byte_en;
    logic [1:0]                          o_ack;
    logic [1:0]                          o_rd_vld;
    logic [WORD_BIT_WIDTH-1:0]           o_rd_data;
    logic                                o_ram_we;
    logic [WORD_ADDR_BIT_WIDTH-1:0]      o_ram_word_addr;
    logic [BE_W-1:0]                     o_ram_wr_byte_en;
    logic [WORD_BIT_WIDTH-1:0]           o_ram_wr_data;
    logic [WORD_BIT_WIDTH-1:0]           i_ram_rd_data;

    modport slave (
        input  i_req, i_req_is_wr, i_req_word_addr, i_req_wr_data, i_req_wr_byte_en,
        input  i_ram_rd_data,
        output o_ack, o_rd_vld, o_rd_data,
        output o_ram_we, o_ram_word_addr, o_ram_wr_byte_en, o_ram_wr_data
    );

    modport master (
        output i_req, i_req_is_wr, i_req_word_addr, i_req_wr_data, i_req_wr_byte_en,
        output i_ram_rd_data,
        input  o_ack, o_rd_vld, o_rd_data,
        input  o_ram_we, o_ram_word_addr, o_ram_wr_byte_en, o_ram_wr_data
    );
endinterface

// File: rtl/csr_ram_port_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between the CSR bridge (0)
// and the datapath engine (1). It registers the RAM command and tags read returns with the issuer.
module csr_ram_port_arbiter #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int WORD_ADDR_BIT_WIDTH = 6,
    parameter int RAM_RD_LAT          = 1
) (
    input logic i_clk,
    input logic i_rst,
    csr_ram_port_arbiter_if.slave bus
);
    localparam int BE_W = WORD_BIT_WIDTH / 8;

    logic                           last_gnt;
    logic                           gnt_vld;
    logic                           gnt_id;
    logic                           gnt_is_rd;
    logic                           ram_we_q;
    logic [WORD_ADDR_BIT_WIDTH-1:0] ram_addr_q;
    logic [BE_W-1:0]                ram_be_q;
    logic [WORD_BIT_WIDTH-1:0]      ram_data_q;
    logic [RAM_RD_LAT:0]            pipe_vld;
    logic [RAM_RD_LAT:0]            pipe_id;

    // Under contention the pointer hands the grant to whoever did not win last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (!i_rst) begin
            case (bus.i_req)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_id  = ~last_gnt;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_id  = 1'b0;
                end
            endcase
        end
    end

    assign gnt_is_rd = gnt_vld & ~bus.i_req_is_wr[gnt_id];
    assign bus.o_ack = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_gnt   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_be_q   <= '0;
            ram_data_q <= '0;
        end else if (gnt_vld) begin
            last_gnt   <= gnt_id;
            ram_we_q   <= bus.i_req_is_wr[gnt_id];
            ram_addr_q <= bus.i_req_word_addr[gnt_id];
            ram_data_q <= bus.i_req_wr_data[gnt_id];
            ram_be_q   <= bus.i_req_is_wr[gnt_id] ? bus.i_req_wr_byte_en[gnt_id] : '0;
        end else begin
            ram_we_q <= 1'b0;
            ram_be_q <= '0;
        end
    end

    // Stage 0 corresponds to the command cycle; the last stage lines up with RAM data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            pipe_vld <= {pipe_vld[RAM_RD_LAT-1:0], gnt_is_rd};
            pipe_id  <= {pipe_id[RAM_RD_LAT-1:0], gnt_id};
        end
    end

    assign bus.o_rd_vld = pipe_vld[RAM_RD_LAT] ? (pipe_id[RAM_RD_LAT] ? 2'b10 : 2'b01) : 2'b00;
    assign bus.o_rd_data        = i_rst ? '0 : bus.i_ram_rd_data;
    assign bus.o_ram_we         = ram_we_q;
    assign bus.o_ram_word_addr  = ram_addr_q;
    assign bus.o_ram_wr_byte_en = ram_be_q;
    assign bus.o_ram_wr_data    = ram_data_q;
endmodule

// File: tb/tb_csr_ram_port_arbiter.sv
// Directed bench: three arbiter instances (read latency 1, 2, 3) share one set of
// request stimulus; each one has its own RAM read model returning a fixed per-address pattern.
module tb_csr_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [1:0]       req;
    logic [1:0]       is_wr;
    logic [1:0][5:0]  addr;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  be;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_ram_port_arbiter_if #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6)) if1 ();
    csr_ram_port_arbiter_if #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6)) if2 ();
    csr_ram_port_arbiter_if #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6)) if3 ();

    csr_ram_port_arbiter #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6), .RAM_RD_LAT(1))
        dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    csr_ram_port_arbiter #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6), .RAM_RD_LAT(2))
        dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));
    csr_ram_port_arbiter #(.WORD_BIT_WIDTH(32), .WORD_ADDR_BIT_WIDTH(6), .RAM_RD_LAT(3))
        dut3 (.i_clk(clk), .i_rst(rst), .bus(if3));

    assign if1.i_req = req;            assign if2.i_req = req;            assign if3.i_req = req;
    assign if1.i_req_is_wr = is_wr;    assign if2.i_req_is_wr = is_wr;    assign if3.i_req_is_wr = is_wr;
    assign if1.i_req_word_addr = addr; assign if2.i_req_word_addr = addr; assign if3.i_req_word_addr = addr;
    assign if1.i_req_wr_data = wdata;  assign if2.i_req_wr_data = wdata;  assign if3.i_req_wr_data = wdata;
    assign if1.i_req_wr_byte_en = be;  assign if2.i_req_wr_byte_en = be;  assign if3.i_req_wr_byte_en = be;

    function automatic logic [31:0] ram_val(input logic [5:0] a);
        return (a == 6'd5) ? 32'hDEADBEEF : (32'h1234_0000 | {26'd0, a});
    endfunction

    logic [31:0] rp1 [1];
    logic [31:0] rp2 [2];
    logic [31:0] rp3 [3];
    always_ff @(posedge clk) begin
        rp1[0] <= ram_val(if1.o_ram_word_addr);
        rp2[0] <= ram_val(if2.o_ram_word_addr);
        rp2[1] <= rp2[0];
        rp3[0] <= ram_val(if3.o_ram_word_addr);
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign if1.i_ram_rd_data = rp1[0];
    assign if2.i_ram_rd_data = rp2[1];
    assign if3.i_ram_rd_data = rp3[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        step();
        #1;
        checks++; if (if1.o_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", if1.o_ack); end
        checks++; if (if1.o_rd_vld !== 2'b00) begin errors++; $display("FAIL reset_rd_vld: got %b expected 00", if1.o_rd_vld); end
        checks++; if (if1.o_ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", if1.o_ram_we); end
        checks++; if (if1.o_ram_word_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %h expected 00", if1.o_ram_word_addr); end
        checks++; if (if1.o_ram_wr_byte_en !== 4'd0) begin errors++; $display("FAIL reset_be: got %b expected 0000", if1.o_ram_wr_byte_en); end
        checks++; if (if1.o_ram_wr_data !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", if1.o_ram_wr_data); end
        checks++; if (if1.o_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", if1.o_rd_data); end
        req = 2'b00;
    endtask

    task automatic test_single_read();
        do_reset();
        req = 2'b01; is_wr = 2'b00; addr[0] = 6'h05; be[0] = 4'hF; wdata[0] = 32'h0;
        #1;
        checks++; if (if1.o_ack !== 2'b01) begin errors++; $display("FAIL rd_ack: got %b expected 01", if1.o_ack); end
        step();
        req = 2'b00;
        #1;
        checks++; if (if1.o_ram_word_addr !== 6'h05) begin errors++; $display("FAIL rd_addr: got %h expected 05", if1.o_ram_word_addr); end
        checks++; if (if1.o_ram_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b expected 0", if1.o_ram_we); end
        checks++; if (if1.o_ram_wr_byte_en !== 4'd0) begin errors++; $display("FAIL rd_be: got %b expected 0000", if1.o_ram_wr_byte_en); end
        checks++; if (if1.o_rd_vld !== 2'b00) begin errors++; $display("FAIL rd_vld_early: got %b expected 00", if1.o_rd_vld); end
        step();
        #1;
        checks++; if (if1.o_rd_vld !== 2'b01) begin errors++; $display("FAIL rd_vld: got %b expected 01", if1.o_rd_vld); end
        checks++; if (if1.o_rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", if1.o_rd_data); end
        step();
        #1;
        checks++; if (if1.o_rd_vld !== 2'b00) begin errors++; $display("FAIL rd_vld_late: got %b expected 00", if1.o_rd_vld); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack;
        logic [5:0] exp_addr;
        rst = 1'b1;
        req = 2'b11; is_wr = 2'b11;
        addr[0] = 6'd1; wdata[0] = 32'h11; be[0] = 4'hF;
        addr[1] = 6'd2; wdata[1] = 32'h22; be[1] = 4'hF;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (if1.o_ack !== exp_ack) begin errors++; $display("FAIL cont_ack[%0d]: got %b expected %b", k, if1.o_ack, exp_ack); end
            if (k == 0) begin
                checks++; if (if1.o_ram_we !== 1'b0) begin errors++; $display("FAIL cont_we_first: got %b expected 0", if1.o_ram_we); end
            end else begin
                exp_addr = ((k - 1) % 2 == 0) ? 6'd1 : 6'd2;
                checks++; if (if1.o_ram_we !== 1'b1) begin errors++; $display("FAIL cont_we[%0d]: got %b expected 1", k, if1.o_ram_we); end
                checks++; if (if1.o_ram_word_addr !== exp_addr) begin errors++; $display("FAIL cont_addr[%0d]: got %h expected %h", k, if1.o_ram_word_addr, exp_addr); end
                checks++; if (if1.o_ram_wr_data !== {26'd0, exp_addr} * 32'h11) begin errors++; $display("FAIL cont_wdata[%0d]: got %h expected %h", k, if1.o_ram_wr_data, {26'd0, exp_addr} * 32'h11); end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 2'b01; is_wr = 2'b01; be[0] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            addr[0] = 6'(10 + k);
            wdata[0] = 32'(k + 100);
            #1;
            checks++; if (if1.o_ack !== 2'b01) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected 01", k, if1.o_ack); end
            if (k > 0) begin
                checks++; if (if1.o_ram_word_addr !== 6'(9 + k) || if1.o_ram_we !== 1'b1) begin
                    errors++; $display("FAIL b2b_cmd[%0d]: got addr %h we %b expected addr %h we 1", k, if1.o_ram_word_addr, if1.o_ram_we, 6'(9 + k));
                end
            end
            step();
        end
        req = 2'b00;
    endtask

    task automatic test_interleaved();
        do_reset();
        req = 2'b01; is_wr = 2'b00; addr[0] = 6'd3; addr[1] = 6'd4;
        #1;
        checks++; if (if3.o_ack !== 2'b01) begin errors++; $display("FAIL il_ack0: got %b expected 01", if3.o_ack); end
        step();
        req = 2'b10;
        #1;
        checks++; if (if3.o_ack !== 2'b10) begin errors++; $display("FAIL il_ack1: got %b expected 10", if3.o_ack); end
        step();
        req = 2'b00;
        for (int c = 2; c <= 6; c++) begin
            #1;
            case (c)
                4: begin
                    checks++; if (if3.o_rd_vld !== 2'b01) begin errors++; $display("FAIL il_vld0: got %b expected 01", if3.o_rd_vld); end
                    checks++; if (if3.o_rd_data !== ram_val(6'd3)) begin errors++; $display("FAIL il_data0: got %h expected %h", if3.o_rd_data, ram_val(6'd3)); end
                end
                5: begin
                    checks++; if (if3.o_rd_vld !== 2'b10) begin errors++; $display("FAIL il_vld1: got %b expected 10", if3.o_rd_vld); end
                    checks++; if (if3.o_rd_data !== ram_val(6'd4)) begin errors++; $display("FAIL il_data1: got %h expected %h", if3.o_rd_data, ram_val(6'd4)); end
                end
                default: begin
                    checks++; if (if3.o_rd_vld !== 2'b00) begin errors++; $display("FAIL il_vld_idle[%0d]: got %b expected 00", c, if3.o_rd_vld); end
                end
            endcase
            step();
        end
    endtask

    task automatic test_byte_en();
        do_reset();
        req = 2'b10; is_wr = 2'b10; addr[1] = 6'd7; wdata[1] = 32'hAABBCCDD; be[1] = 4'b0101;
        #1;
        checks++; if (if1.o_ack !== 2'b10) begin errors++; $display("FAIL be_ack: got %b expected 10", if1.o_ack); end
        step();
        req = 2'b00;
        #1;
        checks++; if (if1.o_ram_we !== 1'b1) begin errors++; $display("FAIL be_we: got %b expected 1", if1.o_ram_we); end
        checks++; if (if1.o_ram_wr_byte_en !== 4'b0101) begin errors++; $display("FAIL be_be: got %b expected 0101", if1.o_ram_wr_byte_en); end
        checks++; if (if1.o_ram_wr_data !== 32'hAABBCCDD) begin errors++; $display("FAIL be_wdata: got %h expected aabbccdd", if1.o_ram_wr_data); end
        checks++; if (if1.o_ram_word_addr !== 6'd7) begin errors++; $display("FAIL be_addr: got %h expected 07", if1.o_ram_word_addr); end
        step();
        #1;
        checks++; if (if1.o_ram_we !== 1'b0) begin errors++; $display("FAIL be_idle_we: got %b expected 0", if1.o_ram_we); end
        checks++; if (if1.o_ram_wr_byte_en !== 4'd0) begin errors++; $display("FAIL be_idle_be: got %b expected 0000", if1.o_ram_wr_byte_en); end
        checks++; if (if1.o_ram_wr_data !== 32'hAABBCCDD || if1.o_ram_word_addr !== 6'd7) begin
            errors++; $display("FAIL be_hold: got data %h addr %h expected aabbccdd 07", if1.o_ram_wr_data, if1.o_ram_word_addr);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req = 2'b01; is_wr = 2'b00; addr[0] = 6'd5;
        #1;
        checks++; if (if2.o_ack !== 2'b01) begin errors++; $display("FAIL rmr_ack: got %b expected 01", if2.o_ack); end
        step();
        req = 2'b00;
        #1;
        checks++; if (if2.o_ram_word_addr !== 6'd5) begin errors++; $display("FAIL rmr_addr_pre: got %h expected 05", if2.o_ram_word_addr); end
        rst = 1'b1;
        #1;
        checks++; if (if2.o_ram_word_addr !== 6'd0 || if2.o_ram_we !== 1'b0 || if2.o_ack !== 2'b00) begin
            errors++; $display("FAIL rmr_outs: got addr %h we %b ack %b expected 00 0 00", if2.o_ram_word_addr, if2.o_ram_we, if2.o_ack);
        end
        checks++; if (if2.o_rd_vld !== 2'b00 || if2.o_rd_data !== 32'd0) begin
            errors++; $display("FAIL rmr_rd: got vld %b data %h expected 00 0", if2.o_rd_vld, if2.o_rd_data);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (if2.o_rd_vld !== 2'b00) begin errors++; $display("FAIL rmr_no_vld[%0d]: got %b expected 00", c, if2.o_rd_vld); end
            step();
        end
        req = 2'b11; is_wr = 2'b00;
        #1;
        checks++; if (if2.o_ack !== 2'b01) begin errors++; $display("FAIL rmr_first_gnt: got %b expected 01", if2.o_ack); end
        step();
        req = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00; is_wr = 2'b00; addr = '0; wdata = '0; be = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_interleaved();
        test_byte_en();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_ram_port_arbiter.md
# csr_ram_port_arbiter

Shares one single-port register-file RAM between two masters: requester 0 (the CSR-to-RAM bridge, RAM side) and requester 1 (a datapath engine). Each cycle it grants at most one request using round-robin arbitration and issues the access to the RAM through registered command outputs. It routes read data back to the issuing requester after the RAM read latency.

## Interface
- WORD_BIT_WIDTH, 32, word width; power of 2, ≥8
- WORD_ADDR_BIT_WIDTH, 6, word address width
- RAM_RD_LAT, 1, cycles from command on o_ram_* to valid i_ram_rd_data; range 1..4
- i_clk  input  1  clock
- i_rst  input  1  reset; asynchronous, active-high
- i_req[n]  input  1  access request, n∈{0,1}; held until ack
- i_req_is_wr[n]  input  1  1 = write, 0 = read
- i_req_word_addr[n]  input  WORD_ADDR_BIT_WIDTH  word address
- i_req_wr_data[n]  input  WORD_BIT_WIDTH  write data
- i_req_wr_byte_en[n]  input  WORD_BIT_WIDTH/8  byte enables
- o_ack[n]  output  1  request accepted this cycle
- o_rd_vld[n]  output  1  read data valid for requester n
- o_rd_data  output  WORD_BIT_WIDTH  read data, shared by both requesters
- o_ram_we  output  1  RAM write enable
- o_ram_word_addr  output  WORD_ADDR_BIT_WIDTH  RAM address
- o_ram_wr_byte_en  output  WORD_BIT_WIDTH/8  RAM byte enables
- o_ram_wr_data  output  WORD_BIT_WIDTH  RAM write data
- i_ram_rd_data  input  WORD_BIT_WIDTH  RAM read data

## Operation
- Request payload must stay stable while i_req[n]=1 and o_ack[n]=0. The arbiter samples the payload in the ack cycle.
- Arbitration is combinational from i_req and the priority pointer `last_gnt`, which is 1 bit and resets to 1, so requester 0 wins first.
  - Only one requester active: it is granted.
  - Both active: grant goes to `~last_gnt`.
  - On every grant, `last_gnt` takes the granted index at the clock edge.
- o_ack[n] is a combinational one-cycle pulse in the grant cycle. At most one ack is high per cycle. A held request receives one ack per grant; to issue back-to-back accesses, keep i_req high and change the payload after each ack.
- Command register: on a grant, the next edge loads the payload into the o_ram_* outputs. o_ram_we = i_req_is_wr of the winner.
  - For a read, o_ram_wr_byte_en = 0.
  - In a cycle with no grant, the next edge sets o_ram_we = 0 and o_ram_wr_byte_en = 0. Address and write data hold their previous values.
- Read-return tracking: a shift pipeline of depth RAM_RD_LAT+1, with each stage holding {vld, id}. A granted read enters the pipeline with vld=1 and id=n; writes and idle cycles enter vld=0.
  - The output stage drives o_rd_vld[id] for one cycle.
  - o_rd_data = i_ram_rd_data, passed through combinationally.
- Reset, asynchronous: all outputs 0, all pipeline stages invalid, last_gnt = 1. Reset mid-operation discards in-flight reads; no o_rd_vld is produced for them after reset releases.
- Full throughput: one access per cycle. Reads and writes may interleave freely. The RAM handles read-after-write to the same address per its own semantics; the arbiter adds no forwarding.

## Timing
- Grant in cycle t → o_ack high in t → o_ram_* valid in t+1.
- Read granted in t → o_rd_vld[n] high in t+1+RAM_RD_LAT, together with the matching o_rd_data.
- Write granted in t → o_ram_we high in exactly cycle t+1, for one cycle only.
- Both requesters continuously active → grants alternate 0,1,0,1,… and each requester gets 50% of cycles.
- A single continuously active requester is granted every cycle with no bubbles.
- Out of reset, o_ram_we = 0 until the first edge after a write grant.

## Test plan
- Single read, RAM_RD_LAT=1: req0 reads addr 0x05 at t, RAM returns 0xDEADBEEF → o_ack[0] at t, o_ram_word_addr=0x05 with o_ram_we=0 at t+1, o_rd_vld[0]=1 with o_rd_data=0xDEADBEEF at t+2, o_rd_vld[1]=0 throughout.
- Contention: both requesters hold req from reset, req0 writing 0x11 to addr 1, req1 writing 0x22 to addr 2 → acks go 0,1,0,1. o_ram_we=1 every cycle from t+1, with addresses alternating 1,2,1,2.
- Interleaved read tagging, RAM_RD_LAT=3: req0 reads addr 3, then req1 reads addr 4 in the following cycle → o_rd_vld[0] at t+4, o_rd_vld[1] at t+5, each carrying the data for its own address.
- Byte-enable write: req1 writes 0xAABBCCDD with byte_en=4'b0101 → o_ram_wr_byte_en=4'b0101 and o_ram_wr_data=0xAABBCCDD for one cycle, then byte_en=0 and we=0 when idle.
- Reset mid-read: assert i_rst one cycle after a req0 read ack with RAM_RD_LAT=2 → all outputs 0 immediately, no o_rd_vld after release, and the first contended grant after reset goes to req0.
